// File: rtl/dmni_brlite_svc_buffer_pkg.sv
// Shared types for the DMNI BrLite service receive path: packet layout,
// MMR addresses and the default service buffer depth.
package dmni_brlite_svc_buffer_pkg;

    localparam int BRLITE_SVC_BUFFER_SIZE = 8;

    typedef struct packed {
        logic [31:0] payload;
        logic [15:0] seq_source;
        logic [15:0] producer;
        logic [7:0]  ksvc;
    } brlite_svc_t;

    typedef enum logic [7:0] {
        DMNI_BR_SVC_POP      = 8'h40,
        DMNI_BR_SVC_KSVC     = 8'h44,
        DMNI_BR_SVC_PRODUCER = 8'h48,
        DMNI_BR_SVC_PAYLOAD  = 8'h4C
    } dmni_mmr_t;

endpackage

// File: rtl/dmni_fifo.sv
// Generic first-word-fall-through FIFO: the head entry is always visible on
// rdata, and push/pop requests that would overflow/underflow are ignored.
module dmni_fifo #(
    parameter  int WIDTH = 72,
    parameter  int DEPTH = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             push_en;
    logic             pop_en;

    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign rdata   = mem[rptr];

    // Pointers are exactly log2(DEPTH) wide, so wrap needs no explicit modulo.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_en) wptr <= wptr + 1'b1;
            if (pop_en)  rptr <= rptr + 1'b1;
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/dmni_brlite_svc_buffer.sv
// BrLite service receive buffer: router handshake into a FWFT FIFO, head
// fields exposed for MMR reads, level interrupt while entries are pending.
module dmni_brlite_svc_buffer
    import dmni_brlite_svc_buffer_pkg::*;
#(
    parameter  int SVC_BUFFER_SIZE = BRLITE_SVC_BUFFER_SIZE,
    localparam int CW              = $clog2(SVC_BUFFER_SIZE) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          rx_i,
    output logic          rx_ack_o,
    input  logic [71:0]   rx_data_i,
    input  logic          pop_i,
    output logic [7:0]    head_ksvc_o,
    output logic [15:0]   head_producer_o,
    output logic [31:0]   head_payload_o,
    output logic [15:0]   head_seq_source_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          irq_o
);

    logic        push_fire;
    logic        pop_fire;
    logic [71:0] rdata;
    logic [CW-1:0] count_next;
    brlite_svc_t head;

    // Ack depends only on registered state (and reset), never on rx_i.
    assign rx_ack_o  = !full_o && !rst_i;
    assign push_fire = rx_i && rx_ack_o;
    assign pop_fire  = pop_i && !empty_o;

    dmni_fifo #(
        .WIDTH (72),
        .DEPTH (SVC_BUFFER_SIZE)
    ) fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push_fire),
        .pop   (pop_fire),
        .wdata (rx_data_i),
        .rdata (rdata),
        .count (count_o),
        .empty (empty_o),
        .full  (full_o)
    );

    assign head              = empty_o ? '0 : brlite_svc_t'(rdata);
    assign head_ksvc_o       = head.ksvc;
    assign head_producer_o   = head.producer;
    assign head_payload_o    = head.payload;
    assign head_seq_source_o = head.seq_source;

    // Track the occupancy the FIFO will hold after this edge so irq changes
    // on the same edge as the count instead of lagging a cycle.
    assign count_next = count_o + CW'(push_fire) - CW'(pop_fire);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) irq_o <= 1'b0;
        else       irq_o <= (count_next != '0);
    end

endmodule

// File: tb/tb_dmni_brlite_svc_buffer.sv
// Directed self-checking bench for dmni_brlite_svc_buffer.
module tb_dmni_brlite_svc_buffer;

    logic        clk;
    logic        rst;
    logic        rx;
    logic        rx_ack;
    logic [71:0] rx_data;
    logic        pop;
    logic [7:0]  head_ksvc;
    logic [15:0] head_producer;
    logic [31:0] head_payload;
    logic [15:0] head_seq_source;
    logic [3:0]  count;
    logic        empty;
    logic        full;
    logic        irq;

    int vectorCount = 0;
    int missCount   = 0;
    logic [7:0] sb [$];

    dmni_brlite_svc_buffer #(.SVC_BUFFER_SIZE(8)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .rx_i              (rx),
        .rx_ack_o          (rx_ack),
        .rx_data_i         (rx_data),
        .pop_i             (pop),
        .head_ksvc_o       (head_ksvc),
        .head_producer_o   (head_producer),
        .head_payload_o    (head_payload),
        .head_seq_source_o (head_seq_source),
        .count_o           (count),
        .empty_o           (empty),
        .full_o            (full),
        .irq_o             (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [71:0] mk(input logic [7:0] k);
        return {24'hC0FFEE, k, 8'h5E, k, 8'h9D, k, k};
    endfunction

    task automatic checkOutput(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        vectorCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, step past the edge, then idle the inputs.
    task automatic applyStimulus(input logic r, input logic [71:0] d, input logic p);
        rx      = r;
        rx_data = d;
        pop     = p;
        @(posedge clk);
        #1;
        rx      = 1'b0;
        rx_data = '0;
        pop     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rx = 1'b0; rx_data = '0; pop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("ack_in_reset", rx_ack, 0);
        rst = 1'b0;
        #1;
        checkOutput("rst_ack",   rx_ack, 1);
        checkOutput("rst_empty", empty, 1);
        checkOutput("rst_full",  full, 0);
        checkOutput("rst_irq",   irq, 0);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_head",  {head_payload, head_seq_source, head_producer, head_ksvc}, 0);
        applyStimulus(0, '0, 1);
        checkOutput("pop_empty_count", count, 0);
        checkOutput("pop_empty_empty", empty, 1);

        applyStimulus(1, {32'hDEADBEEF, 16'h0102, 16'h0304, 8'h05}, 0);
        checkOutput("one_payload",  head_payload, 32'hDEADBEEF);
        checkOutput("one_seq",      head_seq_source, 16'h0102);
        checkOutput("one_producer", head_producer, 16'h0304);
        checkOutput("one_ksvc",     head_ksvc, 8'h05);
        checkOutput("one_count",    count, 1);
        checkOutput("one_irq",      irq, 1);
        checkOutput("one_empty",    empty, 0);
        applyStimulus(0, '0, 1);
        checkOutput("one_pop_count", count, 0);
        checkOutput("one_pop_irq",   irq, 0);
        checkOutput("one_pop_head",  head_payload, 0);

        for (int k = 1; k <= 8; k++) applyStimulus(1, mk(8'(k)), 0);
        checkOutput("fill_full",  full, 1);
        checkOutput("fill_ack",   rx_ack, 0);
        checkOutput("fill_count", count, 8);
        applyStimulus(1, mk(8'd9), 0);
        checkOutput("held_count", count, 8);
        checkOutput("held_head",  head_ksvc, 1);
        applyStimulus(1, mk(8'd9), 1);
        checkOutput("fullpop_count", count, 7);
        checkOutput("fullpop_head",  head_ksvc, 2);
        checkOutput("fullpop_ack",   rx_ack, 1);
        checkOutput("fullpop_pl",    head_payload, 32'hC0FFEE02);
        applyStimulus(1, mk(8'd9), 0);
        checkOutput("ninth_count", count, 8);
        checkOutput("ninth_full",  full, 1);
        for (int k = 2; k <= 9; k++) begin
            checkOutput($sformatf("drain_%0d", k), head_ksvc, 8'(k));
            applyStimulus(0, '0, 1);
        end
        checkOutput("drain_empty", empty, 1);
        checkOutput("drain_irq",   irq, 0);

        for (int k = 1; k <= 20; k++) begin
            if (sb.size() == 3) begin
                checkOutput($sformatf("wrap_%0d", sb[0]), head_ksvc, sb[0]);
                void'(sb.pop_front());
                applyStimulus(1, mk(8'(k)), 1);
            end else begin
                applyStimulus(1, mk(8'(k)), 0);
            end
            sb.push_back(8'(k));
            checkOutput("wrap_occ", count, 4'(sb.size()));
        end
        while (sb.size() > 0) begin
            checkOutput($sformatf("wrap_%0d", sb[0]), head_ksvc, sb[0]);
            void'(sb.pop_front());
            applyStimulus(0, '0, 1);
        end
        checkOutput("wrap_empty", empty, 1);

        for (int k = 8'h31; k <= 8'h34; k++) applyStimulus(1, mk(8'(k)), 0);
        checkOutput("sim_pre_head", head_ksvc, 8'h31);
        applyStimulus(1, mk(8'h35), 1);
        checkOutput("sim_count", count, 4);
        checkOutput("sim_head",  head_ksvc, 8'h32);
        checkOutput("sim_full",  full, 0);

        applyStimulus(1, mk(8'h36), 0);
        checkOutput("mid_count", count, 5);
        rx = 1'b1; rx_data = mk(8'h37); rst = 1'b1;
        #1;
        checkOutput("mid_rst_count", count, 0);
        checkOutput("mid_rst_empty", empty, 1);
        checkOutput("mid_rst_irq",   irq, 0);
        checkOutput("mid_rst_ack",   rx_ack, 0);
        checkOutput("mid_rst_head",  head_ksvc, 0);
        @(posedge clk);
        #1;
        checkOutput("mid_rst_hold", count, 0);
        rst = 1'b0; rx = 1'b0; rx_data = '0;
        #1;
        checkOutput("post_rst_ack", rx_ack, 1);
        applyStimulus(1, mk(8'h77), 0);
        checkOutput("fresh_ksvc",  head_ksvc, 8'h77);
        checkOutput("fresh_pl",    head_payload, 32'hC0FFEE77);
        checkOutput("fresh_count", count, 1);
        checkOutput("fresh_irq",   irq, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/dmni_brlite_svc_buffer.md
Name: dmni_brlite_svc_buffer

Overview:
- Receive-side buffer between the BrLite router local output port and the DMNI MMR file.
- Accepts brlite_svc_t service packets over a valid/ack handshake and stores them in a first-word-fall-through FIFO.
- Exposes the head entry to the MMR reads DMNI_BR_SVC_KSVC, DMNI_BR_SVC_PRODUCER and DMNI_BR_SVC_PAYLOAD.
- Software consumes the head by writing DMNI_BR_SVC_POP; an interrupt request stays asserted while data is pending.

Parameters:
- SVC_BUFFER_SIZE, 8: FIFO depth in entries; must be a power of two, ≥2.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset, asynchronous, active-high
- rx_i  input  1  router presents a valid packet on rx_data_i
- rx_ack_o  output  1  buffer accepts; transfer occurs on a clock edge with rx_i && rx_ack_o
- rx_data_i  input  72  brlite_svc_t {payload[31:0], seq_source[15:0], producer[15:0], ksvc[7:0]}
- pop_i  input  1  single-cycle strobe from MMR decode on a write to DMNI_BR_SVC_POP
- head_ksvc_o  output  8  ksvc of head entry
- head_producer_o  output  16  producer of head entry
- head_payload_o  output  32  payload of head entry
- head_seq_source_o  output  16  seq_source of head entry
- count_o  output  $clog2(SVC_BUFFER_SIZE)+1  number of stored entries
- empty_o  output  1  count_o == 0
- full_o  output  1  count_o == SVC_BUFFER_SIZE
- irq_o  output  1  !empty_o, registered

Behaviour:
- Reset (async, active-high):
  - Write/read pointers and count cleared.
  - rx_ack_o=0 while rst_i is high; it follows !full after reset release.
  - empty_o=1, full_o=0, irq_o=0, count_o=0.
  - head_* outputs = 0 while empty.
- Storage: SVC_BUFFER_SIZE x 72-bit array, with pointers of $clog2(SVC_BUFFER_SIZE) bits that wrap naturally; count_o tracks occupancy.
- rx_ack_o = !full_o, combinational from registered state only. It is never a function of rx_i, so there are no combinational loops through the router.
- Push: on an edge with rx_i && rx_ack_o:
  - rx_data_i is written at wptr.
  - wptr increments modulo depth; count +1.
- Pop: on an edge with pop_i && !empty_o:
  - rptr increments modulo depth; count -1.
  - pop_i while empty is ignored; no state change and no error.
- Simultaneous push and pop (not full, not empty): both occur and count is unchanged.
- Full with pop_i and rx_i asserted in the same cycle: only the pop occurs, because ack was 0. The push is accepted next cycle.
- Empty with push: the entry is visible on head_* in the cycle after the edge (one-cycle write-to-head latency). empty_o falls on the same edge.
- Head read is combinational from array[rptr], masked to 0 when empty. After a pop, the next entry is visible the cycle after the pop edge.
- irq_o is a flop: set on the edge where count becomes nonzero, cleared on the edge where count becomes zero. It is level-sensitive; no per-entry pulse.
- No packet is ever dropped. Backpressure is the only flow control.
- Reset mid-transfer: any in-flight handshake is discarded and all stored entries are lost.

Decomposition:
- Uses existing DMNIPkg types:
  - brlite_svc_t for rx_data_i and storage.
  - dmni_mmr_t values DMNI_BR_SVC_POP/KSVC/PRODUCER/PAYLOAD in the MMR decoder that drives pop_i and muxes the head_* outputs.
- Add to DMNIPkg: parameter BRLITE_SVC_BUFFER_SIZE = 8, used as the top-level default for SVC_BUFFER_SIZE.
- One natural sub-module: dmni_fifo, a generic FWFT FIFO parameterised on width and depth. The same sub-module serves the monitor path later.
- This block wraps dmni_fifo with the handshake, head field unpacking and the irq flop.

Test Plan:
- Reset then idle → rx_ack_o=1, empty_o=1, irq_o=0, count_o=0, head_* = 0; pop_i pulse leaves count_o=0.
- Push {payload=32'hDEADBEEF, seq_source=16'h0102, producer=16'h0304, ksvc=8'h05} → next cycle head_payload_o=DEADBEEF, head_producer_o=0304, head_ksvc_o=05, count_o=1, irq_o=1. Pop → count_o=0, irq_o=0.
- Push 8 packets with ksvc=1..8 → full_o=1, rx_ack_o=0. 9th packet (ksvc=9) is held with rx_i high. Pop → head ksvc=2, then ksvc=9 accepted next cycle, count_o=8.
- Pointer wrap: 20 pushes interleaved with pops, max occupancy 3 → heads read out ksvc strictly in push order 1..20 with no loss.
- Simultaneous push+pop with count=4 → count_o stays 4; head advances by exactly one entry.
- Assert rst_i mid-stream with count=5 and rx_i high → outputs immediately return to reset values; after release, the first push shows on head as a fresh entry.
